// File: rtl/nbit_pipe_comparator.sv
// Two-stage pipelined magnitude comparator: per-slice compare, then MSB-first merge.
// Optional two's-complement mode is enabled by defining CMP_SIGNED_EN.
module nbit_pipe_comparator #(
  parameter int unsigned N     = 16,
  parameter int unsigned CHUNK = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
`ifdef CMP_SIGNED_EN
  input  logic             sgn,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lesser,
  output logic             greater,
  output logic             equal,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt
);

  localparam int unsigned NS = N / CHUNK;
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic          s1_load, s2_load, deliver;
  logic [N-1:0]  a_m, b_m;
  logic [NS-1:0] slt_d, slt_q, seq_d, seq_q;
  logic          s1_valid_d, s1_valid_q;
  logic          dec_lt, dec_eq;
  logic          out_valid_d, out_valid_q;
  logic          lesser_d, lesser_q, greater_d, greater_q, equal_d, equal_q;
  logic [CNT_W-1:0] lt_cnt_d, lt_cnt_q, gt_cnt_d, gt_cnt_q, eq_cnt_d, eq_cnt_q;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;
  assign deliver  = out_valid_q && out_ready;

  // Signed compare maps to unsigned by flipping the sign bits (offset binary).
  always_comb begin
    a_m = a;
    b_m = b;
`ifdef CMP_SIGNED_EN
    a_m[N-1] = a[N-1] ^ sgn;
    b_m[N-1] = b[N-1] ^ sgn;
`endif
  end

  // Stage 1: per-slice less-than / equal flags
  always_comb begin
    slt_d      = slt_q;
    seq_d      = seq_q;
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        for (int unsigned i = 0; i < NS; i++) begin
          slt_d[i] = a_m[i*CHUNK +: CHUNK] < b_m[i*CHUNK +: CHUNK];
          seq_d[i] = a_m[i*CHUNK +: CHUNK] == b_m[i*CHUNK +: CHUNK];
        end
      end
    end
  end

  // Ascending scan: the highest differing slice is written last and wins.
  always_comb begin
    dec_lt = 1'b0;
    dec_eq = 1'b1;
    for (int unsigned i = 0; i < NS; i++) begin
      if (!seq_q[i]) begin
        dec_lt = slt_q[i];
        dec_eq = 1'b0;
      end
    end
  end

  // Stage 2: one-hot result; fields keep their last value when no pair arrives
  always_comb begin
    out_valid_d = out_valid_q;
    lesser_d    = lesser_q;
    greater_d   = greater_q;
    equal_d     = equal_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        lesser_d  = !dec_eq && dec_lt;
        greater_d = !dec_eq && !dec_lt;
        equal_d   = dec_eq;
      end
    end
  end

  // Saturating result counters; clear takes priority over a same-cycle delivery.
  always_comb begin
    lt_cnt_d = lt_cnt_q;
    gt_cnt_d = gt_cnt_q;
    eq_cnt_d = eq_cnt_q;
    if (cnt_clr) begin
      lt_cnt_d = '0;
      gt_cnt_d = '0;
      eq_cnt_d = '0;
    end else if (deliver) begin
      if (lesser_q && lt_cnt_q != CntMax)  lt_cnt_d = lt_cnt_q + CntOne;
      if (greater_q && gt_cnt_q != CntMax) gt_cnt_d = gt_cnt_q + CntOne;
      if (equal_q && eq_cnt_q != CntMax)   eq_cnt_d = eq_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slt_q       <= '0;
      seq_q       <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      lesser_q    <= 1'b0;
      greater_q   <= 1'b0;
      equal_q     <= 1'b0;
      lt_cnt_q    <= '0;
      gt_cnt_q    <= '0;
      eq_cnt_q    <= '0;
    end else begin
      slt_q       <= slt_d;
      seq_q       <= seq_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      lesser_q    <= lesser_d;
      greater_q   <= greater_d;
      equal_q     <= equal_d;
      lt_cnt_q    <= lt_cnt_d;
      gt_cnt_q    <= gt_cnt_d;
      eq_cnt_q    <= eq_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign lesser    = lesser_q;
  assign greater   = greater_q;
  assign equal     = equal_q;
  assign lt_cnt    = lt_cnt_q;
  assign gt_cnt    = gt_cnt_q;
  assign eq_cnt    = eq_cnt_q;

endmodule

// File: doc/nbit_pipe_comparator.md
# nbit_pipe_comparator

Pipelined, parametrised-width magnitude comparator with valid/ready handshakes on both sides and saturating result counters. Each operand pair is split into CHUNK-bit slices that are compared in stage 1, then merged MSB-first in stage 2. It produces a one-hot lesser/greater/equal result at one pair per cycle. The block sits between a streaming data source and downstream decision logic and replaces the single-cycle combinational comparator wherever width or timing requires registering.

## Interface
- N, 16: operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4: slice width for the stage-1 compare; N/CHUNK slices.
- CNT_W, 8: width of each result counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept a pair this cycle.
- a  in  N  operand A.
- b  in  N  operand B.
- sgn  in  1  1 = two's-complement compare, 0 = unsigned. Present only with CMP_SIGNED_EN; sampled with a/b.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- lesser  out  1  a < b.
- greater  out  1  a > b.
- equal  out  1  a == b.
- cnt_clr  in  1  synchronous clear of all three counters.
- lt_cnt, gt_cnt, eq_cnt  out  CNT_W each  count of lesser/greater/equal results delivered.

## Operation
- An input is accepted on in_valid && in_ready. An output is delivered on out_valid && out_ready.
- Stage 1 registers per-slice flags slt[i] and seq[i] for i = 0..N/CHUNK-1, plus a valid bit s1_valid.
- Stage 2 scans slices from the top down. The first slice with seq = 0 decides: lesser = slt, greater = !slt. If every slice has seq = 1, equal = 1.
- Stage 2 registers lesser, greater, equal and out_valid. Exactly one of lesser, greater or equal is 1 whenever out_valid = 1.
- Signed mode (sgn = 1): bit N-1 of both a and b is inverted before slicing (offset binary). No other logic changes.
- Pipeline control:
  - Stage 2 loads when !out_valid || out_ready.
  - Stage 1 loads when !s1_valid || stage 2 loads.
  - in_ready = !s1_valid || stage 2 loads. There is no combinational path from in_valid to in_ready.
- Stall behaviour: while out_valid && !out_ready, out_valid, lesser, greater and equal hold stable. Stage 1 holds its contents. in_ready drops once stage 1 is occupied.
- Counters:
  - On an output handshake, the counter matching the delivered result increments by 1.
  - Each counter saturates at 2^CNT_W-1; no wrap.
  - cnt_clr = 1 sets all three counters to 0 on the next edge.
  - If cnt_clr and a handshake occur in the same cycle, clear wins and the counter ends at 0.
- Reset, asserted at any time: all in-flight pairs are discarded with no output for them. All registers clear.

## Timing
- Reset values: out_valid=0, lesser=0, greater=0, equal=0, lt_cnt=gt_cnt=eq_cnt=0, s1_valid=0. in_ready=1 while rst_n=0 and immediately after release.
- Latency: a pair accepted at edge k gives out_valid=1 after edge k+1, provided no stall. That is 2 registers deep.
- Throughput: 1 pair per cycle with out_ready held at 1.
- Counter update: visible the cycle after the output handshake.
- Results hold their last values while out_valid=0. They are meaningful only when out_valid=1.

## Configuration
- CMP_SIGNED_EN defined:
  - The sgn port exists and is pipelined with its operand pair.
  - Signed and unsigned pairs may be freely interleaved back-to-back.
- CMP_SIGNED_EN undefined:
  - No sgn port and no MSB inversion logic.
  - All compares are unsigned.

## Test plan
- Reset, then a=0x1234, b=0x1234 with out_ready=1 -> out_valid after 2 edges, equal=1, eq_cnt=1; lt_cnt=gt_cnt=0.
- Back-to-back a=0x8000/b=0x7FFF, a=0x0001/b=0x0002, a=0xFFFF/b=0xFFFF, unsigned -> greater, lesser, equal on 3 consecutive cycles; in_ready stays 1.
- CMP_SIGNED_EN, sgn=1, a=0x8000, b=0x7FFF -> lesser=1. Same pair with sgn=0 -> greater=1.
- Hold out_ready=0 and push 3 pairs:
  - Exactly 2 pairs are accepted, then in_ready=0.
  - Output stays stable.
  - Release out_ready -> both results are delivered in order, then in_ready=1.
- CNT_W=2, deliver 5 lesser results -> lt_cnt saturates at 3. Next, cnt_clr asserted on the same cycle as a lesser handshake -> lt_cnt=0.
- Assert rst_n=0 with 2 pairs in flight -> out_valid=0 and counters 0 immediately. After release, no stale result appears.
